// File: rtl/mdu_hilo.sv
// MIPS32 multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue, held for a fixed latency, then committed to HI/LO.
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_load;
  logic [31:0]   r_hi, r_lo, r_hi_next, r_lo_next;
  logic [31:0]   w_hi_res, w_lo_res;
  logic          w_accept;
  op_t           w_op;

  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx, w_prod_s, w_prod_u;
  logic [31:0] w_divisor, w_a_mag, w_b_mag, w_q_mag, w_r_mag;
  logic [31:0] w_quo_s, w_rem_s, w_quo_u, w_rem_u;

  assign w_op = op_t'(op);
  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

  assign w_a_sx   = {{32{a[31]}}, a};
  assign w_b_sx   = {{32{b[31]}}, b};
  assign w_a_zx   = {32'd0, a};
  assign w_b_zx   = {32'd0, b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = w_a_zx * w_b_zx;

  // Zero divisor is substituted so the dividers never see 0; the result is discarded anyway.
  assign w_divisor = (b == '0) ? 32'd1 : b;
  assign w_quo_u   = a / w_divisor;
  assign w_rem_u   = a % w_divisor;

  // Signed division on magnitudes: 0x80000000 / -1 naturally yields LO=0x80000000, HI=0.
  assign w_a_mag = a[31] ? (~a + 32'd1) : a;
  assign w_b_mag = w_divisor[31] ? (~w_divisor + 32'd1) : w_divisor;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_quo_s = (a[31] ^ w_divisor[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem_s = a[31] ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    w_hi_res   = r_hi;
    w_lo_res   = r_lo;
    w_cnt_load = '0;
    case (w_op)
      OP_MULT: begin
        w_hi_res   = w_prod_s[63:32];
        w_lo_res   = w_prod_s[31:0];
        w_cnt_load = CW'(MULT_CYCLES);
      end
      OP_MULTU: begin
        w_hi_res   = w_prod_u[63:32];
        w_lo_res   = w_prod_u[31:0];
        w_cnt_load = CW'(MULT_CYCLES);
      end
      OP_DIV: begin
        if (b != '0) begin
          w_hi_res = w_rem_s;
          w_lo_res = w_quo_s;
        end
        w_cnt_load = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        if (b != '0) begin
          w_hi_res = w_rem_u;
          w_lo_res = w_quo_u;
        end
        w_cnt_load = CW'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (w_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hi_next <= '0;
      r_lo_next <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_hi_next <= w_hi_res;
        r_lo_next <= w_lo_res;
        r_cnt     <= w_cnt_load;
      end else if (start && (w_op == OP_MTHI)) begin
        r_hi <= a;
      end else if (start && (w_op == OP_MTLO)) begin
        r_lo <= a;
      end
    end else begin
      if (r_cnt == CW'(1)) begin
        r_hi  <= r_hi_next;
        r_lo  <= r_lo_next;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed scoreboard bench for mdu_hilo: expected HI/LO pairs are queued at issue
// and compared when busy drops; inputs change and outputs are sampled on negedges.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
    res_t r;
    r.hi = h;
    r.lo = l;
    sb_q.push_back(r);
  endtask

  task automatic pop_check(input string tag);
    res_t r;
    if (sb_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      r = sb_q.pop_front();
      chk({tag, " hi"}, hi, r.hi);
      chk({tag, " lo"}, lo, r.lo);
    end
  endtask

  // Called on a negedge; returns on the next negedge with start dropped.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycles,
                           input logic [31:0] old_hi, input logic [31:0] old_lo);
    int n;
    n = 0;
    chk({tag, " hold hi"}, hi, old_hi);
    chk({tag, " hold lo"}, lo, old_lo);
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(exp_cycles));
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post-rst busy", {31'd0, busy}, 32'd0);
    chk("post-rst lo", lo, 32'h0);

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(3'd1, 32'hFFFFFFFE, 32'h3);
    wait_done("mult", 5, 32'h0, 32'h0);

    push_exp(32'h00000002, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFE, 32'h3);
    wait_done("multu", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd3, 32'hFFFFFFF9, 32'h2);
    wait_done("div", 10, 32'h00000002, 32'hFFFFFFFA);

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd4, 32'h7, 32'h0);
    wait_done("divu0", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);

    push_exp(32'h00000000, 32'h80000000);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div ovf", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);

    start = 1'b1;
    op    = 3'd5;
    a     = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    op = 3'd6;
    a  = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    chk("mtlo lo", lo, 32'h9ABCDEF0);
    chk("mtlo hi", hi, 32'h12345678);
    chk("mtlo busy", {31'd0, busy}, 32'd0);

    push_exp(32'h0, 32'h6);
    issue(3'd1, 32'h2, 32'h3);
    chk("ign busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    op    = 3'd6;
    a     = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    wait_done("mult ign", 4, 32'h12345678, 32'h9ABCDEF0);

    push_exp(32'h0, 32'd20);
    issue(3'd1, 32'd4, 32'd5);
    wait_done("b2b 1", 5, 32'h0, 32'h6);
    push_exp(32'h0, 32'd42);
    issue(3'd2, 32'd6, 32'd7);
    wait_done("b2b 2", 5, 32'h0, 32'd20);

    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    chk("mid-div busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async rst hi", hi, 32'h0);
    chk("async rst lo", lo, 32'h0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("after rst hi", hi, 32'h0);
    chk("after rst lo", lo, 32'h0);
    chk("after rst busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with HI/LO registers for the pipelined MIPS32 core. It sits in the EX stage directly downstream of the 3-input forwarding muxes, whose outputs are its `a` and `b` operands. It executes mult/multu/div/divu over a fixed multi-cycle latency and handles mthi/mtlo. It exposes `busy` so the hazard unit can stall mfhi/mflo and further MDU instructions in ID.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: busy duration for div/divu (must be ≥1).

Ports:
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low; clears all state immediately.
- `a` input, 32 bits: rs operand, already forwarded.
- `b` input, 32 bits: rt operand, already forwarded.
- `op` input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `start` input, 1 bit: qualifies `op` for one cycle; driven low when the instruction is a bubble or flushed.
- `busy` output, 1 bit: an operation is in flight.
- `hi` output, 32 bits: architectural HI register.
- `lo` output, 32 bits: architectural LO register.

## Operation
- The block has two states: IDLE and RUN, with a down-counter `cnt` of width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).
- In IDLE, when `start` is 1 and `op` is 1–4:
  - The block computes the result from the current `a` and `b` and latches it into internal `hi_next`/`lo_next`.
  - It loads `cnt` with MULT_CYCLES or DIV_CYCLES and moves to RUN.
- Arithmetic:
  - mult: signed 32×32 product into 64 bits. HI gets [63:32], LO gets [31:0].
  - multu: the same, unsigned.
  - div: signed. LO gets the quotient, truncated toward zero. HI gets the remainder, which takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Division by zero (`b`=0) for div or divu:
  - The block still enters RUN for DIV_CYCLES.
  - HI and LO are left unchanged at completion; `hi_next`/`lo_next` are loaded with the current `hi`/`lo`.
- Signed overflow, div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- In IDLE, when `start` is 1 and `op` is 5 (mthi): `hi` <= `a` on that edge. When `op` is 6 (mtlo): `lo` <= `a`. No state change.
- In RUN, `cnt` decrements each cycle. When `cnt`=1:
  - `hi`/`lo` <= `hi_next`/`lo_next` on that edge.
  - The block returns to IDLE.
- `start` while in RUN is ignored for every `op`. The hazard unit must stall; the block does not queue requests.
- On reset assertion at any time, including mid-RUN:
  - `hi`=0, `lo`=0, `busy`=0, state IDLE, `cnt`=0.
  - The in-flight result is discarded.
- Outputs after reset: `busy`=0, `hi`=0x00000000, `lo`=0x00000000.

## Timing
- `busy` is registered: `busy` = (state==RUN).
- With `start` sampled at the edge ending cycle T, `busy` is high in cycles T+1 through T+N, where N is the configured latency.
- `hi`/`lo` show the new result from cycle T+N+1, the same cycle `busy` is low again.
- A new `start` is accepted in cycle T+N+1, giving back-to-back throughput of one operation per N+1 cycles.
- mthi/mtlo have 1-cycle latency: the value is visible the cycle after `start`, and `busy` stays low.
- `hi`/`lo` hold their old values throughout RUN. A mfhi that is not stalled would read the pre-operation value; the hazard unit must stall mfhi/mflo while `busy` is high.
- Removing `reset` is sampled synchronously by design. The first `start` is accepted on the first rising edge with `reset`=1.

## Test plan
- **Reset:** hold `reset`=0, then release. Expect `hi`=0, `lo`=0, `busy`=0. Assert `reset`=0 in the 3rd RUN cycle of a div: outputs clear immediately, and HI/LO stay 0 after release.
- **mult:** `a`=0xFFFFFFFE (−2), `b`=0x00000003, op=1. Expect `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **multu:** same operands, op=2. Expect HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- **div:** `a`=0xFFFFFFF9 (−7), `b`=2, op=3. Expect `busy` for 10 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Then divu with `a`=7, `b`=0: HI/LO remain unchanged after 10 busy cycles.
- **mthi/mtlo and ignore-while-busy:**
  - mthi `a`=0x12345678, then mtlo `a`=0x9ABCDEF0 on the next cycle. Expect HI/LO updated one cycle after each, with `busy` never high.
  - Start mult 2×3, then pulse `start` with mtlo `a`=0xDEADBEEF during RUN. Expect LO=6 at completion, with the mtlo dropped.
- **Back-to-back:** mult 4×5, then multu 6×7 started on the first cycle `busy` is low. Expect LO=20, then LO=42, with no lost or merged operation.
